// File: rtl/spi_slave_regfile_pkg.sv
// Shared definitions for the SPI slave register file and the SPI command
// decoder: fixed register indices, the status register index and the
// wrap-around pointer increment.
package spi_slave_regfile_pkg;

    // Control register: bit QPI_BIT enables QPI mode.
    localparam int REG_CTRL  = 32'sd0;
    // Dummy-cycle count register.
    localparam int REG_DUMMY = 32'sd1;
    localparam int QPI_BIT   = 32'sd0;

    // The status register is always the last entry of the bank.
    function automatic int status_idx(input int num_regs);
        return num_regs - 32'sd1;
    endfunction

    // Next pointer value. The wrap is a compare against the last index, not
    // a bit overflow, so non-power-of-two banks wrap correctly.
    function automatic int wrap_inc(input int addr, input int num_regs);
        if (addr >= num_regs - 32'sd1) begin
            return 32'sd0;
        end else begin
            return addr + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/spi_slave_addr_ptr.sv
// Auto-incrementing register pointer for burst access.
// Ports:
//   sclk, rstn  : clock, asynchronous active-low reset
//   start       : pulse that loads the pointer from start_addr
//   start_addr  : first register of the burst (out of range loads 0)
//   advance     : a write or read-ack was accepted; step past eff_addr
//   eff_addr    : register addressed this cycle (start_addr while start)
//   cur_addr    : current pointer value
module spi_slave_addr_ptr
    import spi_slave_regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] eff_addr,
    output logic [ADDR_W-1:0] cur_addr
);

    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] start_sane_s;
    logic [ADDR_W-1:0] eff_s;
    logic [ADDR_W-1:0] ptr_next_s;

    // Clamp an out-of-range start address to 0 and select the effective address.
    always_comb begin
        start_sane_s = '0;
        if (32'(start_addr) < NUM_REGS) begin
            start_sane_s = start_addr;
        end else begin
            start_sane_s = '0;
        end
        if (start) begin
            eff_s = start_sane_s;
        end else begin
            eff_s = ptr_r;
        end
    end

    // Advance takes priority over a plain load, and steps only once even
    // when a write and a read-ack coincide.
    always_comb begin
        ptr_next_s = ptr_r;
        if (advance) begin
            ptr_next_s = ADDR_W'(wrap_inc(32'(eff_s), NUM_REGS));
        end else if (start) begin
            ptr_next_s = start_sane_s;
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign eff_addr = eff_s;
    assign cur_addr = ptr_r;

endmodule

// File: rtl/spi_slave_regfile.sv
// Configuration/status register file for the SPI slave (sclk domain).
// NUM_REGS registers of REG_SIZE bits with an auto-incrementing pointer for
// burst reads/writes. The last register is a sticky status register: hardware
// events set bits, writing 1 clears them, and a set beats a same-cycle clear.
// Ports:
//   sclk, rstn           : clock, asynchronous active-low reset
//   start, start_addr    : begin a burst at start_addr
//   wr_data, wr_data_valid : write to the addressed register, then advance
//   rd_ack               : read data consumed, advance
//   rd_data              : register at the pointer (combinational)
//   cur_addr             : pointer value
//   hw_status            : event pulses ORed into the status register
//   regs_flat            : all registers, register i at [i*REG_SIZE +: REG_SIZE]
//   en_qpi               : control register bit 0
module spi_slave_regfile
    import spi_slave_regfile_pkg::*;
#(
    parameter int REG_SIZE = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                         sclk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [REG_SIZE-1:0]          wr_data,
    input  logic                         wr_data_valid,
    input  logic                         rd_ack,
    output logic [REG_SIZE-1:0]          rd_data,
    output logic [ADDR_W-1:0]            cur_addr,
    input  logic [REG_SIZE-1:0]          hw_status,
    output logic [NUM_REGS*REG_SIZE-1:0] regs_flat,
    output logic                         en_qpi
);

    localparam int                STATUS_IDX  = status_idx(NUM_REGS);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_IDX);

    logic [REG_SIZE-1:0] regs_r [NUM_REGS];
    logic [ADDR_W-1:0]   eff_addr_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic [REG_SIZE-1:0] clr_s;
    logic [REG_SIZE-1:0] rd_data_s;

    spi_slave_addr_ptr #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_addr_ptr (
        .sclk       (sclk),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .advance    (wr_data_valid | rd_ack),
        .eff_addr   (eff_addr_s),
        .cur_addr   (cur_addr_s)
    );

    // Write-1-to-clear mask for the status register.
    always_comb begin
        clr_s = '0;
        if (wr_data_valid && (eff_addr_s == STATUS_ADDR)) begin
            clr_s = wr_data;
        end else begin
            clr_s = '0;
        end
    end

    // Register storage: plain overwrite below the status register; status is
    // cleared first and then set, so a coincident event wins.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == STATUS_IDX) begin
                    regs_r[i] <= (regs_r[i] & ~clr_s) | hw_status;
                end else if (wr_data_valid && (eff_addr_s == ADDR_W'(i))) begin
                    regs_r[i] <= wr_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read mux on the pointer (not on eff_addr); reads have no side effects.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_addr_s == ADDR_W'(i)) begin
                rd_data_s = regs_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_SIZE +: REG_SIZE] = regs_r[g];
    end

    assign rd_data  = rd_data_s;
    assign cur_addr = cur_addr_s;
    assign en_qpi   = regs_r[REG_CTRL][QPI_BIT];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile with a six-entry bank: directed
// scenarios plus random traffic against an array-based reference model.
module tb_spi_slave_regfile;

    localparam int RS = 8;
    localparam int NR = 6;
    localparam int AW = 3;

    logic            sclk;
    logic            rstn;
    logic            start;
    logic [AW-1:0]   start_addr;
    logic [RS-1:0]   wr_data;
    logic            wr_data_valid;
    logic            rd_ack;
    logic [RS-1:0]   rd_data;
    logic [AW-1:0]   cur_addr;
    logic [RS-1:0]   hw_status;
    logic [NR*RS-1:0] regs_flat;
    logic            en_qpi;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents and pointer.
    logic [RS-1:0] m_regs [NR];
    int            m_ptr;

    spi_slave_regfile #(.REG_SIZE(RS), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .sclk          (sclk),
        .rstn          (rstn),
        .start         (start),
        .start_addr    (start_addr),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .cur_addr      (cur_addr),
        .hw_status     (hw_status),
        .regs_flat     (regs_flat),
        .en_qpi        (en_qpi)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*RS-1:0] model_flat();
        logic [NR*RS-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*RS +: RS] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_ptr = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cur"},  64'(cur_addr),  64'(m_ptr));
        check({tag, "_rd"},   64'(rd_data),   64'(m_regs[m_ptr]));
        check({tag, "_flat"}, 64'(regs_flat), 64'(model_flat()));
        check({tag, "_qpi"},  64'(en_qpi),    64'(m_regs[0][0]));
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input logic st, input logic [AW-1:0] sa, input logic wv,
                        input logic [RS-1:0] wd, input logic ra, input logic [RS-1:0] hw);
        int eff;
        logic [RS-1:0] clr;
        start = st; start_addr = sa; wr_data_valid = wv; wr_data = wd;
        rd_ack = ra; hw_status = hw;
        #1;
        if (ra) check("rd_before_ack", 64'(rd_data), 64'(m_regs[m_ptr]));
        eff = st ? ((int'(sa) < NR) ? int'(sa) : 0) : m_ptr;
        clr = (wv && eff == NR - 1) ? wd : '0;
        if (wv && eff != NR - 1) m_regs[eff] = wd;
        m_regs[NR-1] = (m_regs[NR-1] & ~clr) | hw;
        if (wv || ra) m_ptr = (eff + 1) % NR;
        else if (st) m_ptr = eff;
        @(posedge sclk);
        #1;
        start = 1'b0; wr_data_valid = 1'b0; rd_ack = 1'b0; hw_status = '0;
        check_all("step");
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; start_addr = '0; wr_data = '0;
        wr_data_valid = 1'b0; rd_ack = 1'b0; hw_status = '0;
        model_reset();
        #12;
        check("reset_rd",   64'(rd_data),   64'd0);
        check("reset_cur",  64'(cur_addr),  64'd0);
        check("reset_qpi",  64'(en_qpi),    64'd0);
        check("reset_flat", 64'(regs_flat), 64'd0);
        @(negedge sclk); rstn = 1'b1;
        @(posedge sclk); #1;

        step(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00);
        check("post_reset_rd", 64'(rd_data), 64'h00);

        // Burst write with wrap: 4 -> 5 (status) -> 0.
        step(1'b1, 3'd4, 1'b1, 8'hA5, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, 8'h3C, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 8'h00);
        check("bw_reg4", 64'(regs_flat[4*RS +: RS]), 64'hA5);
        check("bw_reg5", 64'(regs_flat[5*RS +: RS]), 64'h00);
        check("bw_reg0", 64'(regs_flat[0*RS +: RS]), 64'h01);
        check("bw_qpi",  64'(en_qpi),   64'd1);
        check("bw_cur",  64'(cur_addr), 64'd1);

        // Burst read.
        step(1'b1, 3'd1, 1'b1, 8'h11, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, 8'h22, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, 8'h33, 1'b0, 8'h00);
        step(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("br_first", 64'(rd_data), 64'h11);
        step(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("br_second", 64'(rd_data), 64'h22);
        step(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("br_third", 64'(rd_data), 64'h33);
        step(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("br_cur", 64'(cur_addr), 64'd4);

        // Status set, clear, and set-wins.
        step(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h81);
        check("st_set", 64'(regs_flat[5*RS +: RS]), 64'h81);
        step(1'b1, 3'd5, 1'b1, 8'h01, 1'b0, 8'h00);
        check("st_clr", 64'(regs_flat[5*RS +: RS]), 64'h80);
        step(1'b1, 3'd5, 1'b1, 8'h80, 1'b0, 8'h80);
        check("st_set_wins", 64'(regs_flat[5*RS +: RS]), 64'h80);

        // Simultaneous write and read-ack.
        step(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b1, 8'h5A, 1'b1, 8'h00);
        check("sim_reg2", 64'(regs_flat[2*RS +: RS]), 64'h5A);
        check("sim_cur",  64'(cur_addr), 64'd3);

        // Out-of-range start.
        step(1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 8'h00);
        check("oor_cur", 64'(cur_addr), 64'd0);
        check("oor_rd",  64'(rd_data),  64'h01);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        // Mid-burst asynchronous reset.
        start = 1'b1; start_addr = 3'd3; wr_data_valid = 1'b1; wr_data = 8'hFF;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_rd",   64'(rd_data),   64'd0);
        check("midrst_cur",  64'(cur_addr),  64'd0);
        check("midrst_qpi",  64'(en_qpi),    64'd0);
        check("midrst_flat", 64'(regs_flat), 64'd0);
        start = 1'b0; wr_data_valid = 1'b0; wr_data = '0;
        model_reset();
        @(negedge sclk); rstn = 1'b1;
        @(posedge sclk); #1;
        step(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00);
        check("midrst_after_rd", 64'(rd_data), 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

Parametrised configuration/status register file for the SPI slave, clocked in the `sclk` domain. It generalises the fixed four-entry register bank to `NUM_REGS` entries with an internal auto-incrementing address pointer, so a single SPI command can burst-read or burst-write consecutive registers. The top register is a sticky, write-1-to-clear status register set by hardware events. It sits between the SPI command decoder and the slave's control logic (QPI enable, dummy-cycle count, status flags).

## Interface
- `REG_SIZE`, default 8: width of each register in bits.
- `NUM_REGS`, default 8: number of registers; must be at least 2 (index `NUM_REGS-1` is the status register).
- `ADDR_W`, default 3: pointer width; must equal `$clog2(NUM_REGS)`.

- `sclk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse; loads the pointer from `start_addr`.
- `start_addr`, input, `ADDR_W`: first register of the burst.
- `wr_data`, input, `REG_SIZE`: write data.
- `wr_data_valid`, input, 1: write `wr_data` to the addressed register, then advance the pointer.
- `rd_ack`, input, 1: the decoder has consumed `rd_data`; advance the pointer.
- `rd_data`, output, `REG_SIZE`: contents of the addressed register.
- `cur_addr`, output, `ADDR_W`: current pointer value.
- `hw_status`, input, `REG_SIZE`: per-bit event pulses, ORed into the status register.
- `regs_flat`, output, `NUM_REGS*REG_SIZE`: all registers, with register *i* at bits [*i*·`REG_SIZE` +: `REG_SIZE`].
- `en_qpi`, output, 1: register 0, bit 0.

## Operation
- **Reset state.** All registers are 0 and the pointer is 0. Consequently `rd_data`, `regs_flat`, `en_qpi` and `cur_addr` are all 0.
- **Effective address.**
  - `eff_addr` is `start_addr` when `start` is high, otherwise the pointer.
  - A write in the same cycle as `start` targets `start_addr`.
- **Pointer update (once per cycle).**
  - If `wr_data_valid` or `rd_ack` is high: pointer ← `eff_addr` + 1.
  - Else if `start` is high: pointer ← `start_addr`.
  - Else the pointer holds.
  - When both `wr_data_valid` and `rd_ack` are high, the pointer advances only once.
- **Wrap-around.** Incrementing from `NUM_REGS-1` gives 0. This holds for non-power-of-two `NUM_REGS`, so the increment is a compare, not a bit overflow.
- **Out of range.** A `start_addr` ≥ `NUM_REGS` loads 0.
- **Writes to registers 0 … `NUM_REGS-2`.** Plain overwrite.
- **Status register (`NUM_REGS-1`).**
  - Next value = (current & ~(`wr_data` if written this cycle, else 0)) | `hw_status`.
  - If a hardware set and a write-1-to-clear hit the same bit in the same cycle, the set wins.
  - `hw_status` is sampled every cycle, independent of writes.
- **Read data.** `rd_data` is a combinational mux of the register at the *pointer*, not at `eff_addr`. Reading has no side effects.

## Timing
- Write latency is one edge: data is visible on `rd_data` and `regs_flat` after the `sclk` edge that samples `wr_data_valid`.
- `rd_data` follows the pointer combinationally. After `start` at edge N, `rd_data` shows register `start_addr` from edge N onward.
- A burst read of K registers is `start`, then K `rd_ack` pulses. The decoder samples `rd_data` before the edge carrying each `rd_ack`.
- A `hw_status` pulse is visible in the status register one edge later.
- Asserting `rstn` mid-burst clears all registers and the pointer immediately, with no edge required. After release, the first `sclk` edge behaves as from reset.
- There is no back-pressure: every `wr_data_valid` and `rd_ack` is accepted on the cycle it is presented.

## Structure
- A shared package holds:
  - localparams for register indices: `REG_CTRL` = 0 (bit 0 = QPI enable) and `REG_DUMMY` = 1.
  - a function giving the status register index, `NUM_REGS-1`.
  - the wrap-increment function, shared with the SPI command decoder.
- The pointer logic (load, increment, wrap) is a natural sub-module: `spi_slave_addr_ptr`.
- Storage, the write-1-to-clear logic and the read mux stay in the top module.

## Test plan
- **Reset.** `rstn`=0 mid-stream → `rd_data`=0, `cur_addr`=0, `en_qpi`=0, `regs_flat`=0. After release, `start` with `start_addr`=2 → `rd_data`=0x00.
- **Burst write with wrap.** `NUM_REGS`=6; `start` with `start_addr`=4 together with a write of 0xA5, then writes 0x3C and 0x01 → reg4=0xA5, reg5 status unchanged (writing 0x3C to an all-zero status clears nothing), reg0=0x01, `en_qpi`=1, `cur_addr`=1.
- **Burst read.** Preload reg1=0x11, reg2=0x22, reg3=0x33; `start` with `start_addr`=1, then 3 `rd_ack` pulses → `rd_data` sequence 0x11, 0x22, 0x33; `cur_addr`=4.
- **Status set and clear.** `hw_status`=0x81 for one cycle → status=0x81. Write 0x01 to status → 0x80. Write 0x80 with `hw_status`=0x80 in the same cycle → status stays 0x80 (set wins).
- **Simultaneous write and read-ack.** `wr_data_valid` and `rd_ack` high together at pointer 2 → reg2 written, `cur_addr`=3 (single increment).
- **Out-of-range start.** `NUM_REGS`=6, `start_addr`=7 → `cur_addr`=0, `rd_data` = reg0.
